// File: rtl/quad_sample_decoder.sv
// 4x quadrature decoder: synchronises A/B and a divided sample clock, debounces A/B
// at each sample point, then turns Gray-code steps into a wrapping signed position.
module quad_sample_decoder #(
   parameter int POS_W    = 16,
   parameter int DEBOUNCE = 2,
   parameter int ERR_W    = 8
) (
   input  logic                    i_clk_in,
   input  logic                    i_rst_n,
   input  logic                    i_sample_clk,
   input  logic                    i_quad_a,
   input  logic                    i_quad_b,
   input  logic                    i_clr,
   output logic signed [POS_W-1:0] o_position,
   output logic                    o_dir,
   output logic                    o_step,
   output logic                    o_err,
   output logic        [ERR_W-1:0] o_err_count
);

   localparam logic [3:0] DB_MAX = 4'(DEBOUNCE);

   logic             r_a_meta, r_a_sync;
   logic             r_b_meta, r_b_sync;
   logic             r_s_meta, r_s_sync, r_s_dly;
   logic             r_sample_en;
   logic [1:0]       r_cand;
   logic [3:0]       r_cnt;
   logic             r_hit;
   logic [1:0]       r_filt;
   logic             r_new_flt;
   logic [1:0]       r_prev;
   logic             r_primed;
   logic [POS_W-1:0] r_position;
   logic             r_dir;
   logic             r_step;
   logic             r_err;
   logic [ERR_W-1:0] r_err_count;

   logic [1:0]       w_raw;
   logic [3:0]       w_cnt_nxt;
   logic             w_hit;
   logic             w_fwd;
   logic             w_rev;
   logic             w_ill;
   logic             w_evt;

   assign w_raw = {r_a_sync, r_b_sync};
   assign w_evt = r_new_flt & r_primed;

   // A new filtered value is announced only on the sample that brings the run
   // length up to DEBOUNCE, never again while the count sits saturated.
   always_comb begin
      w_cnt_nxt = r_cnt;
      w_hit     = 1'b0;
      if (r_sample_en) begin
         if (w_raw == r_cand) begin
            w_cnt_nxt = (r_cnt == DB_MAX) ? DB_MAX : r_cnt + 4'd1;
         end else begin
            w_cnt_nxt = 4'd1;
         end
         w_hit = (w_cnt_nxt == DB_MAX) && ((w_raw != r_cand) || (r_cnt != DB_MAX));
      end
   end

   always_comb begin
      w_fwd = 1'b0;
      w_rev = 1'b0;
      w_ill = 1'b0;
      case ({r_prev, r_filt})
         4'b0010, 4'b1011, 4'b1101, 4'b0100: w_fwd = 1'b1;
         4'b0001, 4'b0111, 4'b1110, 4'b1000: w_rev = 1'b1;
         4'b0011, 4'b1100, 4'b0110, 4'b1001: w_ill = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge i_clk_in) begin
      if (!i_rst_n) begin
         r_a_meta    <= 1'b0;
         r_a_sync    <= 1'b0;
         r_b_meta    <= 1'b0;
         r_b_sync    <= 1'b0;
         r_s_meta    <= 1'b0;
         r_s_sync    <= 1'b0;
         r_s_dly     <= 1'b0;
         r_sample_en <= 1'b0;
         r_cand      <= 2'b00;
         r_cnt       <= 4'd0;
         r_hit       <= 1'b0;
         r_filt      <= 2'b00;
         r_new_flt   <= 1'b0;
      end else begin
         r_a_meta    <= i_quad_a;
         r_a_sync    <= r_a_meta;
         r_b_meta    <= i_quad_b;
         r_b_sync    <= r_b_meta;
         r_s_meta    <= i_sample_clk;
         r_s_sync    <= r_s_meta;
         r_s_dly     <= r_s_sync;
         r_sample_en <= r_s_sync & ~r_s_dly;
         if (r_sample_en) begin
            r_cand <= w_raw;
         end
         r_cnt     <= w_cnt_nxt;
         r_hit     <= w_hit;
         r_new_flt <= r_hit;
         if (r_hit) begin
            r_filt <= r_cand;
         end
      end
   end

   // clr wins over a same-cycle decode for the count/error state, but the
   // direction and the reference state still track the encoder.
   always_ff @(posedge i_clk_in) begin
      if (!i_rst_n) begin
         r_prev      <= 2'b00;
         r_primed    <= 1'b0;
         r_position  <= '0;
         r_dir       <= 1'b0;
         r_step      <= 1'b0;
         r_err       <= 1'b0;
         r_err_count <= '0;
      end else begin
         r_step <= 1'b0;
         if (r_new_flt) begin
            r_prev   <= r_filt;
            r_primed <= 1'b1;
         end
         if (w_evt && (w_fwd || w_rev)) begin
            r_dir <= w_fwd;
         end
         if (i_clr) begin
            r_position  <= '0;
            r_err       <= 1'b0;
            r_err_count <= '0;
         end else if (w_evt) begin
            if (w_fwd) begin
               r_position <= r_position + POS_W'(1);
               r_step     <= 1'b1;
            end else if (w_rev) begin
               r_position <= r_position - POS_W'(1);
               r_step     <= 1'b1;
            end else if (w_ill) begin
               r_err <= 1'b1;
               if (r_err_count != {ERR_W{1'b1}}) begin
                  r_err_count <= r_err_count + ERR_W'(1);
               end
            end
         end
      end
   end

   assign o_position  = r_position;
   assign o_dir       = r_dir;
   assign o_step      = r_step;
   assign o_err       = r_err;
   assign o_err_count = r_err_count;

endmodule

// File: tb/tb_quad_sample_decoder.sv
// Directed bench for quad_sample_decoder: a 16-bit and a 4-bit position instance
// share one stimulus stream; expected values are hand-derived Gray-code sequences.
module tb_quad_sample_decoder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, sample_clk, qa, qb, clr;
   logic [15:0] pos16;
   logic [3:0]  pos4;
   logic        dir16, step16, err16;
   logic        dir4, step4, err4;
   logic [7:0]  ec16, ec4;

   int errors      = 0;
   int checks      = 0;
   int step_pulses = 0;

   logic [1:0] fwd_seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
   logic [1:0] rev_seq [3] = '{2'b01, 2'b11, 2'b10};

   quad_sample_decoder #(.POS_W(16), .DEBOUNCE(2), .ERR_W(8)) dut16 (
      .i_clk_in(clk), .i_rst_n(rst_n), .i_sample_clk(sample_clk),
      .i_quad_a(qa), .i_quad_b(qb), .i_clr(clr),
      .o_position(pos16), .o_dir(dir16), .o_step(step16),
      .o_err(err16), .o_err_count(ec16)
   );

   quad_sample_decoder #(.POS_W(4), .DEBOUNCE(2), .ERR_W(8)) dut4 (
      .i_clk_in(clk), .i_rst_n(rst_n), .i_sample_clk(sample_clk),
      .i_quad_a(qa), .i_quad_b(qb), .i_clr(clr),
      .o_position(pos4), .o_dir(dir4), .o_step(step4),
      .o_err(err4), .o_err_count(ec4)
   );

   always @(negedge clk) if (step16) step_pulses++;

   initial begin
      #1000000;
      $display("FAIL timeout: got no end of test, expected finish before 1ms");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_ab(input logic [1:0] ab);
      @(posedge clk);
      #1 qa = ab[1];
      qb = ab[0];
   endtask

   task automatic sample_edge();
      @(posedge clk);
      #1 sample_clk = 1'b1;
      repeat (4) @(posedge clk);
      #1 sample_clk = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   task automatic move(input logic [1:0] ab);
      set_ab(ab);
      sample_edge();
      sample_edge();
   endtask

   // Second (qualifying) sample edge is first captured at edge N; the result
   // must appear right after N+5 and be gone after N+6.
   task automatic move_timed(input logic [1:0] ab, input logic exp_step,
                             input logic with_clr, input string tag);
      set_ab(ab);
      sample_edge();
      @(posedge clk);
      #1 sample_clk = 1'b1;
      repeat (5) @(posedge clk);
      #1 check({tag, " early"}, step16, 0);
      clr = with_clr;
      @(posedge clk);
      #1 check({tag, " step"}, step16, exp_step);
      clr = 1'b0;
      @(posedge clk);
      #1 check({tag, " step_low"}, step16, 0);
      sample_clk = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   initial begin
      rst_n = 1'b0; sample_clk = 1'b0; qa = 1'b0; qb = 1'b0; clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst pos", pos16, 0);
      check("rst dir", dir16, 0);
      check("rst step", step16, 0);
      check("rst err", err16, 0);
      check("rst err_count", ec16, 0);
      rst_n = 1'b1;

      repeat (3) sample_edge();
      check("prime pos", pos16, 0);
      check("prime dir", dir16, 0);
      check("prime err", err16, 0);
      check("prime steps", step_pulses, 0);

      for (int i = 0; i < 8; i++) move_timed(fwd_seq[i % 4], 1'b1, 1'b0, "fwd");
      check("fwd pos", pos16, 16'd8);
      check("fwd pos4", pos4, 4'd8);
      check("fwd dir", dir16, 1);
      check("fwd steps", step_pulses, 8);

      for (int i = 0; i < 3; i++) move_timed(rev_seq[i], 1'b1, 1'b0, "rev");
      check("rev pos", pos16, 16'd5);
      check("rev dir", dir16, 0);
      check("rev steps", step_pulses, 11);

      for (int i = 0; i < 6; i++) begin
         set_ab({i[0], 1'b0});
         sample_edge();
      end
      sample_edge();
      check("bounce pos", pos16, 16'd5);
      check("bounce dir", dir16, 0);
      check("bounce err", err16, 0);
      check("bounce steps", step_pulses, 11);

      move_timed(2'b00, 1'b1, 1'b0, "rev_a");
      move_timed(2'b01, 1'b1, 1'b0, "rev_b");
      check("preclr pos", pos16, 16'd3);
      move_timed(2'b00, 1'b0, 1'b1, "clr_hit");
      check("clr_hit pos", pos16, 0);
      check("clr_hit dir", dir16, 1);
      check("clr_hit err", err16, 0);
      move_timed(2'b10, 1'b1, 1'b0, "after_clr");
      check("after_clr pos", pos16, 16'd1);
      check("after_clr dir", dir16, 1);

      move(2'b00);
      check("pre_ill pos", pos16, 0);
      move(2'b11);
      check("ill err", err16, 1);
      check("ill err_count", ec16, 1);
      check("ill pos", pos16, 0);
      check("ill dir", dir16, 0);
      for (int i = 0; i < 299; i++) move((i % 2 == 0) ? 2'b00 : 2'b11);
      check("sat err_count", ec16, 8'd255);
      check("sat err_count4", ec4, 8'd255);
      check("sat err", err16, 1);
      check("sat pos", pos16, 0);

      @(posedge clk);
      #1 clr = 1'b1;
      @(posedge clk);
      #1 clr = 1'b0;
      check("clr pos", pos16, 0);
      check("clr err", err16, 0);
      check("clr err_count", ec16, 0);

      move(2'b01);
      check("wrap_neg pos16", pos16, 16'hFFFF);
      check("wrap_neg pos4", pos4, 4'hF);
      check("wrap_neg dir", dir16, 0);
      for (int i = 0; i < 8; i++) move(fwd_seq[(i + 3) % 4]);
      check("plus7 pos4", pos4, 4'd7);
      move(2'b00);
      check("wrap_pos pos4", pos4, 4'h8);
      check("wrap_pos pos16", pos16, 16'd8);
      check("wrap_pos dir4", dir4, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/quad_sample_decoder.md
Name: quad_sample_decoder

Overview:
- 4x quadrature decoder for encoder channels A/B, sampled only on rising edges of the slow divided clock produced by the clock-divider stage.
- Synchronises A, B and the divided clock into clk_in, then debounces A/B over consecutive sample points.
- Decodes Gray-code transitions into a signed position count, a direction flag and a step strobe, and flags illegal two-bit jumps.
- Outputs feed the display/readout logic.

Parameters:
POS_W, 16, width of signed position counter (two's complement)
DEBOUNCE, 2, consecutive identical samples required before filtered A/B updates (legal range 1..15)
ERR_W, 8, width of saturating error counter

Ports:
clk_in  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
sample_clk  input  1  divided clock from clock-divider stage; treated as data, rising edge = sample point
quad_a  input  1  encoder channel A, asynchronous
quad_b  input  1  encoder channel B, asynchronous
clr  input  1  synchronous clear of position and error state
position  output  POS_W  signed accumulated position
dir  output  1  last valid direction, 1 = forward (A leads B)
step  output  1  one-cycle pulse per valid counted transition
err  output  1  sticky illegal-transition flag
err_count  output  ERR_W  saturating count of illegal transitions

Behaviour:
- Reset (rst_n=0 at clock edge): position=0, dir=0, step=0, err=0, err_count=0. Synchronisers, edge detector, debounce counter and primed flag are cleared. Reset mid-operation discards any partial debounce.
- Synchronisers: two-flop chain each on quad_a, quad_b, sample_clk. A separate delay flop on synced sample_clk drives registered sample_en = synced & ~delayed, high exactly 1 clk_in cycle per sample_clk rising edge. sample_clk held high produces no further sample_en.
- Debounce, evaluated only when sample_en=1, on synced {a,b}:
  - raw == candidate: stable_cnt increments, saturating at DEBOUNCE.
  - raw != candidate: candidate <= raw and stable_cnt <= 1.
  - When stable_cnt reaches DEBOUNCE, filtered <= candidate and new_flt is pulsed for 1 cycle.
  - With DEBOUNCE=1, every sample updates filtered.
- Priming: the first new_flt after reset loads prev_state only, with no count, step or err. primed is then set. clr does not clear primed or filter state.
- Decode, on new_flt with primed=1, comparing prev_state to filtered (bits {a,b}):
  - Forward: 00->10->11->01->00. position+1, dir=1, step=1.
  - Reverse: the opposite sequence. position-1, dir=0, step=1.
  - Same state: no effect.
  - Illegal jumps (00<->11, 01<->10): position and dir unchanged, step=0, err=1, err_count+1 saturating at all-ones.
  - prev_state <= filtered in all cases.
- Arithmetic: position wraps modulo 2^POS_W. Max positive +1 gives most negative, and the reverse.
- Latency: a qualifying sample_clk rising edge first captured at clk_in edge N gives step/position update at edge N+5, provided A/B are stable ≥1 cycle before that edge. step is registered and deasserts at N+6.
- clr=1: position=0, err=0, err_count=0, step=0 on that edge.
  - clr has priority over a simultaneous decode event; that transition is lost from position, but dir and prev_state still update.
  - err_count does not increment on a clr cycle.
- rst_n has priority over clr.

Test Plan:
- Reset/prime: rst_n low 3 cycles, then A/B=00 held for 3 sample_clk edges -> all outputs 0, no step pulse.
- Forward count, DEBOUNCE=2: 8 forward Gray steps, each held 2 sample edges -> position=8, dir=1, exactly 8 single-cycle step pulses, each 5 cycles after its qualifying sample edge. Then 3 reverse steps -> position=5, dir=0.
- Debounce reject: A toggles 0->1->0 on alternating sample edges -> filtered never changes, position unchanged, step never asserted.
- Illegal jump: filtered 00 then 11 -> err=1, err_count=1, position unchanged. Repeat 300 times with ERR_W=8 -> err_count=255.
- Wrap: POS_W=4, reverse step from 0 -> position=-1 (4'hF). Forward from +7 -> -8.
- Clear collision: clr asserted on the same cycle a forward update would occur with position=3 -> position=0, step=0, dir=1. The next forward step gives position=1.
